// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: identifies the faulty CSR replica, confirms persistence, requests resync.
// Optional syndrome capture output is enabled by defining CV32E40P_TMR_FAULT_SYNDROME_EN.
module cv32e40p_tmr_fault_manager #(
   parameter int W       = 32,
   parameter int PERSIST = 2,
   parameter int BLANK   = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     res0_i,
   input  logic [W-1:0]     res1_i,
   input  logic [W-1:0]     res2_i,
   input  logic             check_en_i,
   output logic             resync_req_o,
   output logic [1:0]       resync_id_o,
   input  logic             resync_ack_i,
   output logic             fault_pulse_o,
   output logic             fatal_o,
   output logic             busy_o,
   input  logic             clr_cnt_i,
   output logic [CNT_W-1:0] err_cnt0_o,
   output logic [CNT_W-1:0] err_cnt1_o,
   output logic [CNT_W-1:0] err_cnt2_o
`ifdef CV32E40P_TMR_FAULT_SYNDROME_EN
   ,
   output logic [W-1:0]     syndrome_o
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_CONFIRM, S_REQ, S_BLANK, S_FATAL} state_e;

   state_e           state_q, state_d;
   logic [3:0]       pcnt_q;
   logic [3:0]       blank_q;
   logic [1:0]       id_q;
   logic             pulse_q;
   logic [CNT_W-1:0] cnt_q [3];
   logic             suspect, nomaj, confirm;
   logic [1:0]       sus_id;

   // The odd replica out is the suspect; no pair agreeing means majority is lost.
   always_comb begin
      suspect = 1'b0;
      nomaj   = 1'b0;
      sus_id  = 2'd0;
      if (check_en_i) begin
         if (res0_i == res1_i && res0_i == res2_i) begin
            suspect = 1'b0;
         end else if (res0_i == res1_i) begin
            suspect = 1'b1;
            sus_id  = 2'd2;
         end else if (res0_i == res2_i) begin
            suspect = 1'b1;
            sus_id  = 2'd1;
         end else if (res1_i == res2_i) begin
            suspect = 1'b1;
            sus_id  = 2'd0;
         end else begin
            nomaj = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (nomaj)        state_d = S_FATAL;
            else if (suspect) state_d = (PERSIST == 1) ? S_REQ : S_CONFIRM;
         end
         S_CONFIRM: begin
            if (nomaj)         state_d = S_FATAL;
            else if (!suspect) state_d = S_IDLE;
            else if (sus_id == id_q && (pcnt_q + 4'd1) == 4'(PERSIST))
               state_d = S_REQ;
         end
         S_REQ: begin
            if (nomaj)             state_d = S_FATAL;
            else if (resync_ack_i) state_d = S_BLANK;
         end
         S_BLANK: begin
            if (blank_q == 4'(BLANK - 1)) state_d = S_IDLE;
         end
         S_FATAL: state_d = S_FATAL;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      resync_req_o = (state_q == S_REQ);
      fatal_o      = (state_q == S_FATAL);
      busy_o       = (state_q == S_CONFIRM) || (state_q == S_REQ) || (state_q == S_BLANK);
   end

   assign confirm       = (state_d == S_REQ) && (state_q != S_REQ);
   assign resync_id_o   = id_q;
   assign fault_pulse_o = pulse_q;
   assign err_cnt0_o    = cnt_q[0];
   assign err_cnt1_o    = cnt_q[1];
   assign err_cnt2_o    = cnt_q[2];

   // A change of suspect inside CONFIRM restarts persistence from one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q  <= '0;
         blank_q <= '0;
         id_q    <= '0;
         pulse_q <= 1'b0;
      end else begin
         pulse_q <= confirm;
         if (state_d == S_CONFIRM)
            pcnt_q <= (state_q == S_CONFIRM && sus_id == id_q) ? pcnt_q + 4'd1 : 4'd1;
         else
            pcnt_q <= '0;
         if ((state_q == S_IDLE || state_q == S_CONFIRM) && suspect)
            id_q <= sus_id;
         blank_q <= (state_q == S_BLANK) ? blank_q + 4'd1 : 4'd0;
      end
   end

   // Clear wins over the old value, so a same-cycle confirmation lands at exactly one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (confirm && sus_id == 2'(i)) begin
               if (clr_cnt_i)             cnt_q[i] <= CNT_W'(1);
               else if (cnt_q[i] != '1)   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if (clr_cnt_i) begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

`ifdef CV32E40P_TMR_FAULT_SYNDROME_EN
   logic [W-1:0] syn_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syn_q <= '0;
      end else if (confirm) begin
         case (sus_id)
            2'd0:    syn_q <= res0_i ^ res1_i;
            2'd1:    syn_q <= res1_i ^ res0_i;
            default: syn_q <= res2_i ^ res0_i;
         endcase
      end
   end

   assign syndrome_o = syn_q;
`endif

endmodule

// File: doc/cv32e40p_tmr_fault_manager.md
Name: cv32e40p_tmr_fault_manager

Overview:
- Consumer side of the CSR triple-modular-redundancy scheme.
- The voter masks a disagreeing replica; this block looks at the same three replica output vectors, identifies which replica is faulty, and confirms that the fault persists.
- It then runs a request/acknowledge handshake so the core controller can resynchronise the faulty replica from the voted state.
- Loss of majority is escalated to a sticky fatal alarm.

Parameters:
- W, 32: width of each replica comparison vector. The replica outputs are concatenated by the instantiating wrapper.
- PERSIST, 2: number of consecutive mismatching sampled cycles needed to confirm a fault. Range 1..15.
- BLANK, 4: cycles after an acknowledged resync during which comparison is ignored. Range 1..15.
- CNT_W, 8: width of the per-replica saturating fault counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- res0_i  in  W  replica 0 output vector.
- res1_i  in  W  replica 1 output vector.
- res2_i  in  W  replica 2 output vector.
- check_en_i  in  1  comparison enable. Low means ignore the inputs.
- resync_req_o  out  1  resync request to the controller.
- resync_id_o  out  2  index of the faulty replica (0..2). Valid while resync_req_o is high.
- resync_ack_i  in  1  controller acknowledge that resync is complete.
- fault_pulse_o  out  1  one-cycle pulse when a fault is confirmed.
- fatal_o  out  1  sticky no-majority alarm.
- busy_o  out  1  high in every state except IDLE and FATAL.
- clr_cnt_i  in  1  synchronous clear of all fault counters.
- err_cnt0_o  out  CNT_W  confirmed-fault count for replica 0.
- err_cnt1_o  out  CNT_W  confirmed-fault count for replica 1.
- err_cnt2_o  out  CNT_W  confirmed-fault count for replica 2.

Behaviour:
- Reset: the FSM is in IDLE and every output is 0, including resync_id_o and all counters.
- Per-cycle classification, only when check_en_i=1:
  - All three equal: OK.
  - r0==r1!=r2: suspect id 2.
  - r0==r2!=r1: suspect id 1.
  - r1==r2!=r0: suspect id 0.
  - None equal: NOMAJ.
- FSM state IDLE:
  - Suspect seen: go to CONFIRM, set persist count to 1, latch the suspect id.
  - NOMAJ seen: go to FATAL.
- FSM state CONFIRM:
  - Same suspect again: increment persist count.
  - Different suspect: restart the count at 1 with the new id.
  - OK or check_en_i=0: go to IDLE and clear the count (transient fault, not counted).
  - NOMAJ: go to FATAL.
  - When the count reaches PERSIST: go to REQ.
  - With PERSIST=1 the block moves IDLE to REQ directly.
- Required timing: if the first mismatch is present in input cycle 0 and persists, resync_req_o is high from cycle PERSIST onward.
  - fault_pulse_o pulses in that same cycle.
  - The counter for the faulty replica increments in that same cycle.
- FSM state REQ:
  - resync_req_o=1 and resync_id_o holds the latched id, both stable until acknowledge.
  - Only NOMAJ classification is evaluated; the suspect classification is ignored.
  - resync_ack_i sampled high: go to BLANK. resync_req_o falls in the next cycle.
  - NOMAJ: go to FATAL. resync_req_o falls in the next cycle.
  - check_en_i=0 does not abort REQ.
- FSM state BLANK:
  - Counts BLANK cycles with all comparison ignored, then returns to IDLE.
- FSM state FATAL:
  - fatal_o=1 and resync_req_o=0.
  - Exit only by reset.
  - fatal_o rises the cycle after the first NOMAJ input.
- resync_ack_i outside REQ is ignored.
- Counters:
  - Saturate at 2^CNT_W-1.
  - If clr_cnt_i and an increment occur in the same cycle, the incremented counter becomes 1 and the others become 0.
- Asserting rst_n mid-handshake returns the block to IDLE immediately with all outputs 0.
- The block never modifies the replica values.

Optional Feature:
- Macro: CV32E40P_TMR_FAULT_SYNDROME_EN.
- When defined, the block adds output syndrome_o [W-1:0].
  - On fault confirmation it captures (faulty replica XOR majority value) from the confirming cycle.
  - The value holds until the next confirmation or reset. Reset value is 0.
  - Contents are not updated in FATAL.
- When not defined, the port and its register are absent, and behaviour is otherwise identical.

Test Plan:
- All replicas equal (0x1234_5678) for 100 cycles with check_en_i=1 -> resync_req_o, fault_pulse_o and fatal_o stay 0, and all counters stay 0.
- PERSIST=2: res1_i=0xFFFF_0000 while the others are 0 from cycle 0 onward; ack at cycle 5 -> req high in cycles 2..5 with resync_id_o=1, fault_pulse_o at cycle 2, err_cnt1_o=1, busy_o drops after the 4 BLANK cycles end.
- One-cycle glitch on res2_i at PERSIST=2 -> no request and no counter change. With the syndrome macro enabled, a persistent 0x0000_0100 flip on res2_i gives syndrome_o=0x0000_0100.
- All three replicas different (1, 2, 3), first in IDLE and again in REQ during a separate run -> fatal_o=1 the next cycle, req drops, and fatal_o holds through an acknowledge until rst_n is asserted.
- CNT_W=2: five confirmed faults on replica 0 -> err_cnt0_o saturates at 3. Then clr_cnt_i in the same cycle as a confirmed fault on replica 2 -> err_cnt0_o=0 and err_cnt2_o=1.
